hpdcache_victim_sel: RTL and testbench

Per-set victim-way selector for the HPDcache refill path. On each miss-allocation request it picks one way of the addressed set, using bit-PLRU (MRU-bit) replacement state that is updated on every hit and refill. It presents the choice as a registered one-hot vector to the refill path's one-hot-to-binary encoder. The block also holds the replacement state for all sets.

---
 rtl/hpdcache_pkg.sv | 14 +
 rtl/hpdcache_prio_1hot.sv | 23 ++
 rtl/hpdcache_victim_sel.sv | 96 +++++++++
 tb/tb_hpdcache_victim_sel.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hpdcache_pkg.sv
// Shared types and helpers for the HPDcache victim selector.
// Victim one-hot type is sized for the default 4-way configuration.
package hpdcache_pkg;

  localparam int HPDCACHE_WAYS = 4;

  typedef logic [HPDCACHE_WAYS-1:0] hpdcache_victim_way_t;

  // Set index width; a single-set cache still needs a 1-bit index port.
  function automatic int hpdcache_set_w(input int sets);
    return (sets > 1) ? $clog2(sets) : 1;
  endfunction

endpackage

// File: rtl/hpdcache_prio_1hot.sv
// Lowest-set-bit priority picker: one-hot of the lowest 1 in the input, zero for zero input.
// Purely combinational, no latency, no flow control.
module hpdcache_prio_1hot #(
  parameter int N = 4
) (
  input  logic [N-1:0] in_vec,
  output logic [N-1:0] out_1hot
);

  logic found;

  always_comb begin
    out_1hot = '0;
    found    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (in_vec[i] && !found) begin
        out_1hot[i] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hpdcache_victim_sel.sv
// Bit-PLRU victim selector with per-set MRU state; registered one-hot victim, 1-cycle latency.
// Single output register: accepts while empty or being drained. Option: HPDCACHE_VICTIM_INVALID_FIRST_EN.
module hpdcache_victim_sel
  import hpdcache_pkg::*;
#(
  parameter  int SETS  = 64,
  parameter  int WAYS  = 4,
  localparam int SET_W = hpdcache_set_w(SETS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sel_req_i,
  output logic             sel_ready_o,
  input  logic [SET_W-1:0] sel_set_i,
  input  logic [WAYS-1:0]  sel_valid_ways_i,
  output logic             victim_valid_o,
  input  logic             victim_ready_i,
  output logic [WAYS-1:0]  victim_way_o,
  input  logic             updt_i,
  input  logic [SET_W-1:0] updt_set_i,
  input  logic [WAYS-1:0]  updt_way_i
);

  logic [WAYS-1:0] mru_q [SETS];
  logic [WAYS-1:0] sel_mru;
  logic [WAYS-1:0] inv_1hot;
  logic [WAYS-1:0] plru_1hot;
  logic [WAYS-1:0] victim_d;
  logic [WAYS-1:0] updt_merged;
  logic [WAYS-1:0] updt_next;
  logic [SETS-1:0] set_we;
  logic            accept;

  assign sel_ready_o = !victim_valid_o || victim_ready_i;
  assign accept      = sel_req_i && sel_ready_o;

  // Selection reads the registered state, so a same-cycle touch is not seen.
  assign sel_mru = mru_q[sel_set_i];

  hpdcache_prio_1hot #(.N(WAYS)) u_prio_invalid (
    .in_vec   (~sel_valid_ways_i),
    .out_1hot (inv_1hot)
  );

  hpdcache_prio_1hot #(.N(WAYS)) u_prio_plru (
    .in_vec   (~sel_mru),
    .out_1hot (plru_1hot)
  );

`ifdef HPDCACHE_VICTIM_INVALID_FIRST_EN
  assign victim_d = (|inv_1hot)  ? inv_1hot  :
                    (|plru_1hot) ? plru_1hot : WAYS'(1);
`else
  logic unused_inv;
  assign unused_inv = |inv_1hot;
  assign victim_d   = (|plru_1hot) ? plru_1hot : WAYS'(1);
`endif

  // A touch that would saturate the set restarts it with only the touched way marked.
  assign updt_merged = mru_q[updt_set_i] | updt_way_i;
  assign updt_next   = (&updt_merged) ? updt_way_i : updt_merged;

  always_comb begin
    set_we = '0;
    for (int s = 0; s < SETS; s++) begin
      set_we[s] = updt_i && (WAYS > 1) && (updt_set_i == SET_W'(s));
    end
  end

  always_ff @(posedge clk_i) begin
    for (int s = 0; s < SETS; s++) begin
      if (rst_i) begin
        mru_q[s] <= '0;
      end else if (set_we[s]) begin
        mru_q[s] <= updt_next;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      victim_valid_o <= 1'b0;
      victim_way_o   <= '0;
    end else if (accept) begin
      victim_valid_o <= 1'b1;
      victim_way_o   <= victim_d;
    end else if (victim_ready_i) begin
      victim_valid_o <= 1'b0;
    end
  end

  // Non-one-hot touches leave the replacement state undefined.
  a_updt_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    updt_i |-> $onehot(updt_way_i));

endmodule

// File: tb/tb_hpdcache_victim_sel.sv
// Directed plus random checks of hpdcache_victim_sel against a behavioural PLRU reference.
module tb_hpdcache_victim_sel;

  localparam int SETS = 8;
  localparam int WAYS = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_req;
  logic       sel_ready;
  logic [2:0] sel_set;
  logic [3:0] sel_valid_ways;
  logic       victim_valid;
  logic       victim_ready;
  logic [3:0] victim_way;
  logic       updt;
  logic [2:0] updt_set;
  logic [3:0] updt_way;

  int total = 0;
  int bad   = 0;

  // Reference state: MRU bits per set plus the expected output register.
  logic [3:0] m_mru [SETS];
  logic       m_valid;
  logic [3:0] m_way;
  logic [3:0] held;

  always #5 clk = ~clk;

  hpdcache_victim_sel #(.SETS(SETS), .WAYS(WAYS)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .sel_req_i        (sel_req),
    .sel_ready_o      (sel_ready),
    .sel_set_i        (sel_set),
    .sel_valid_ways_i (sel_valid_ways),
    .victim_valid_o   (victim_valid),
    .victim_ready_i   (victim_ready),
    .victim_way_o     (victim_way),
    .updt_i           (updt),
    .updt_set_i       (updt_set),
    .updt_way_i       (updt_way)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Victim choice from the rules: first invalid way (if enabled), else first non-MRU way, else way 0.
  function automatic logic [3:0] ref_pick(input int s);
`ifdef HPDCACHE_VICTIM_INVALID_FIRST_EN
    for (int w = 0; w < WAYS; w++)
      if (!sel_valid_ways[w]) return 4'(1 << w);
`endif
    for (int w = 0; w < WAYS; w++)
      if (!m_mru[s][w]) return 4'(1 << w);
    return 4'b0001;
  endfunction

  // One clock: predict the edge from current inputs, advance, compare outputs.
  task automatic tick();
    logic       acc;
    logic [3:0] pick;
    #1;
    if (!rst) check("sel_ready", sel_ready, !m_valid || victim_ready);
    acc  = sel_req && (!m_valid || victim_ready);
    pick = ref_pick(int'(sel_set));
    if (rst) begin
      m_valid = 1'b0;
      m_way   = 4'b0000;
      for (int s = 0; s < SETS; s++) m_mru[s] = 4'b0000;
    end else begin
      if (acc) begin
        m_way   = pick;
        m_valid = 1'b1;
      end else if (victim_ready) begin
        m_valid = 1'b0;
      end
      if (updt) begin
        m_mru[updt_set] = m_mru[updt_set] | updt_way;
        if (m_mru[updt_set] == 4'b1111) m_mru[updt_set] = updt_way;
      end
    end
    @(posedge clk);
    #1;
    check("victim_valid", victim_valid, m_valid);
    check("victim_way", victim_way, m_way);
  endtask

  initial begin
    m_valid        = 1'b0;
    m_way          = 4'b0000;
    for (int s = 0; s < SETS; s++) m_mru[s] = 4'b0000;
    rst            = 1'b1;
    sel_req        = 1'b0;
    sel_set        = 3'd0;
    sel_valid_ways = 4'b1111;
    victim_ready   = 1'b1;
    updt           = 1'b0;
    updt_set       = 3'd0;
    updt_way       = 4'b0001;

    // Reset held two cycles, then first request.
    tick();
    tick();
    check("rst_valid", victim_valid, 1'b0);
    check("rst_way", victim_way, 4'b0000);
    rst     = 1'b0;
    sel_req = 1'b1;
    sel_set = 3'd3;
    tick();
    check("rst_first_req", victim_way, 4'b0001);

    // Touch set 5 ways 0..2, then way 3 which wraps the set.
    sel_req  = 1'b0;
    updt     = 1'b1;
    updt_set = 3'd5;
    for (int w = 0; w < 3; w++) begin
      updt_way = 4'(1 << w);
      tick();
    end
    updt    = 1'b0;
    sel_req = 1'b1;
    sel_set = 3'd5;
    tick();
    check("touch3_req", victim_way, 4'b1000);
    sel_req  = 1'b0;
    updt     = 1'b1;
    updt_way = 4'b1000;
    tick();
    updt    = 1'b0;
    sel_req = 1'b1;
    tick();
    check("touch_wrap_req", victim_way, 4'b0001);

    // Invalid-way preference on a fresh set.
    sel_set        = 3'd2;
    sel_valid_ways = 4'b1011;
    tick();
`ifdef HPDCACHE_VICTIM_INVALID_FIRST_EN
    check("invalid_first", victim_way, 4'b0100);
`else
    check("invalid_ignored", victim_way, 4'b0001);
`endif
    sel_valid_ways = 4'b1111;

    // Backpressure: consumer stalls three cycles while a request waits.
    sel_set = 3'd5;
    tick();
    held         = victim_way;
    victim_ready = 1'b0;
    sel_set      = 3'd6;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready", sel_ready, 1'b0);
      check("bp_stable", victim_way, held);
    end
    victim_ready = 1'b1;
    #1;
    check("bp_release_ready", sel_ready, 1'b1);
    tick();
    check("bp_release_way", victim_way, 4'b0001);
    check("bp_release_valid", victim_valid, 1'b1);

    // Same-cycle touch and request on set 1 with MRU 0110.
    sel_req  = 1'b0;
    updt     = 1'b1;
    updt_set = 3'd1;
    updt_way = 4'b0010;
    tick();
    updt_way = 4'b0100;
    tick();
    updt_way = 4'b0001;
    sel_req  = 1'b1;
    sel_set  = 3'd1;
    tick();
    check("collide_old_state", victim_way, 4'b0001);
    updt = 1'b0;
    tick();
    check("collide_after", victim_way, 4'b1000);

    // Reset pulse while a victim is held.
    victim_ready = 1'b0;
    sel_set      = 3'd0;
    tick();
    check("hold_valid", victim_valid, 1'b1);
    rst = 1'b1;
    tick();
    check("midrst_valid", victim_valid, 1'b0);
    check("midrst_way", victim_way, 4'b0000);
    rst          = 1'b0;
    victim_ready = 1'b1;
    for (int s = 0; s < SETS; s++) begin
      sel_set = 3'(s);
      tick();
      check("post_rst_way", victim_way, 4'b0001);
    end

    // Random traffic against the reference.
    for (int i = 0; i < 600; i++) begin
      rst            = ($urandom_range(0, 79) == 0);
      sel_req        = $urandom_range(0, 3) != 0;
      sel_set        = 3'($urandom_range(0, SETS - 1));
      sel_valid_ways = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b1111;
      victim_ready   = $urandom_range(0, 3) != 0;
      updt           = $urandom_range(0, 1) != 0;
      updt_set       = ($urandom_range(0, 2) == 0) ? sel_set : 3'($urandom_range(0, SETS - 1));
      updt_way       = 4'(1 << $urandom_range(0, WAYS - 1));
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
